// File: rtl/osc_watchdog_if.sv
// Signal bundle for osc_watchdog: monitor controls and the monitored line (master side)
// and the alarm/window status returned by the watchdog (slave side).
interface osc_watchdog_if #(
  parameter int unsigned MAX_EDGES = 4
) ();
  localparam int unsigned CW = $clog2(MAX_EDGES + 2);

  logic          en;
  logic          clear;
  logic          sig_in;
  logic          alarm;
  logic          window_done;
  logic [CW-1:0] last_cnt;
  logic [1:0]    state;

  modport master (
    output en, clear, sig_in,
    input  alarm, window_done, last_cnt, state
  );

  modport slave (
    input  en, clear, sig_in,
    output alarm, window_done, last_cnt, state
  );
endinterface

// File: rtl/osc_watchdog.sv
// Oscillator runaway watchdog: counts sig_in edges per fixed window of clock cycles and
// raises a sticky alarm when a window sees more than MAX_EDGES edges.
module osc_watchdog #(
  parameter int unsigned WINDOW    = 16,
  parameter int unsigned MAX_EDGES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  osc_watchdog_if.slave io_bus
);
  localparam int unsigned CW = $clog2(MAX_EDGES + 2);
  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [CW-1:0] MaxEdges = CW'(MAX_EDGES);
  localparam logic [CW-1:0] SatCnt   = CW'(MAX_EDGES + 1);
  localparam logic [WW-1:0] WLast    = WW'(WINDOW - 1);
  localparam logic [WW-1:0] WOne     = WW'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StAlarm = 2'd2
  } state_e;

  logic          r_s1, r_s2, r_prev;
  state_e        r_state;
  logic [WW-1:0] r_wcnt;
  logic [CW-1:0] r_edge_cnt;
  logic          r_alarm;
  logic          r_done;
  logic [CW-1:0] r_last;

  logic          w_edge;
  logic [CW-1:0] w_sum;

  // edge_cnt never exceeds MAX_EDGES while counting, so w_sum cannot overflow CW bits
  assign w_edge = r_s2 ^ r_prev;
  assign w_sum  = r_edge_cnt + CW'(w_edge);

  // Synchronizer keeps running in every state so no edge is seen twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= io_bus.sig_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_wcnt     <= '0;
      r_edge_cnt <= '0;
      r_alarm    <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= '0;
    end else if (io_bus.clear) begin
      r_wcnt     <= '0;
      r_edge_cnt <= '0;
      r_alarm    <= 1'b0;
      r_done     <= 1'b0;
      r_state    <= io_bus.en ? StCount : StIdle;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_wcnt     <= '0;
          r_edge_cnt <= '0;
          if (io_bus.en) r_state <= StCount;
        end
        StCount: begin
          if (!io_bus.en) begin
            r_state    <= StIdle;
            r_wcnt     <= '0;
            r_edge_cnt <= '0;
          end else if (w_sum > MaxEdges) begin
            // Alarm beats a coinciding window end: no pulse, last_cnt untouched
            r_state    <= StAlarm;
            r_alarm    <= 1'b1;
            r_edge_cnt <= SatCnt;
          end else if (r_wcnt == WLast) begin
            r_done     <= 1'b1;
            r_last     <= w_sum;
            r_wcnt     <= '0;
            r_edge_cnt <= '0;
          end else begin
            r_wcnt     <= r_wcnt + WOne;
            r_edge_cnt <= w_sum;
          end
        end
        StAlarm: begin
          r_alarm <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.alarm       = r_alarm;
  assign io_bus.window_done = r_done;
  assign io_bus.last_cnt    = r_last;
  assign io_bus.state       = r_state;
endmodule

// File: tb/tb_osc_watchdog.sv
// Bench for osc_watchdog: directed toggle sequences, a per-cycle reference model compared
// on every falling clock edge, and literal expectations at the key points of each scenario.
module tb_osc_watchdog;
  localparam int unsigned WINDOW    = 16;
  localparam int unsigned MAX_EDGES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  osc_watchdog_if #(.MAX_EDGES(MAX_EDGES)) bus ();

  osc_watchdog #(
    .WINDOW   (WINDOW),
    .MAX_EDGES(MAX_EDGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: sig_in sample history gives the edge seen each cycle
  // (sample two cycles back differs from sample three cycles back).
  int m_state = 0;  // 0 idle, 1 counting, 2 alarm
  int m_pos   = 0;
  int m_cnt   = 0;
  int m_last  = 0;
  int m_total = 0;
  bit m_alarm = 1'b0;
  bit m_done  = 1'b0;
  bit m_edge  = 1'b0;
  bit hist[$] = '{1'b0, 1'b0, 1'b0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_last = 0;
      m_alarm = 1'b0; m_done = 1'b0;
      hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      m_edge = (hist[hist.size()-2] != hist[hist.size()-3]);
      hist.push_back(bus.sig_in);
      void'(hist.pop_front());
      m_done = 1'b0;
      if (bus.clear) begin
        m_pos = 0; m_cnt = 0; m_alarm = 1'b0;
        m_state = bus.en ? 1 : 0;
      end else if (m_state == 0) begin
        if (bus.en) m_state = 1;
      end else if (m_state == 1) begin
        if (!bus.en) begin
          m_state = 0; m_pos = 0; m_cnt = 0;
        end else begin
          m_total = m_cnt + int'(m_edge);
          if (m_total > int'(MAX_EDGES)) begin
            m_state = 2; m_alarm = 1'b1; m_cnt = MAX_EDGES + 1;
          end else if (m_pos == int'(WINDOW) - 1) begin
            m_done = 1'b1; m_last = m_total; m_pos = 0; m_cnt = 0;
          end else begin
            m_pos++; m_cnt = m_total;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_alarm", int'(bus.alarm), int'(m_alarm));
    check("model_window_done", int'(bus.window_done), int'(m_done));
    check("model_last_cnt", int'(bus.last_cnt), m_last);
    check("model_state", int'(bus.state), m_state);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tog();
    bus.sig_in = ~bus.sig_in;
  endtask

  initial begin
    bus.en = 1'b0; bus.clear = 1'b0; bus.sig_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1);
    check("reset_state", int'(bus.state), 0);
    check("reset_alarm", int'(bus.alarm), 0);
    check("reset_done", int'(bus.window_done), 0);
    check("reset_last_cnt", int'(bus.last_cnt), 0);

    // Three spread toggles in the first window
    bus.en = 1'b1;
    step(2); tog(); step(4); tog(); step(4); tog(); step(7);
    check("w1_done", int'(bus.window_done), 1);
    check("w1_last_cnt", int'(bus.last_cnt), 3);
    check("w1_alarm", int'(bus.alarm), 0);
    check("w1_state", int'(bus.state), 1);
    step(1);
    check("w1_done_one_cycle", int'(bus.window_done), 0);

    // Five toggles in one window trip the alarm
    for (int i = 0; i < 5; i++) begin
      tog(); step(2);
    end
    check("pre_alarm", int'(bus.alarm), 0);
    step(1);
    check("alarm_set", int'(bus.alarm), 1);
    check("alarm_state", int'(bus.state), 2);
    tog(); step(3); tog(); step(3);
    check("alarm_sticky", int'(bus.alarm), 1);
    check("alarm_last_frozen", int'(bus.last_cnt), 3);

    // Clear out of alarm, then a two-edge window
    bus.clear = 1'b1; step(1); bus.clear = 1'b0;
    check("clear_alarm", int'(bus.alarm), 0);
    check("clear_state", int'(bus.state), 1);
    tog(); step(3); tog(); step(13);
    check("w_after_clear_done", int'(bus.window_done), 1);
    check("w_after_clear_last", int'(bus.last_cnt), 2);

    // Edge landing in the last cycle of a window belongs to that window
    step(13); tog(); step(3);
    check("boundary_done", int'(bus.window_done), 1);
    check("boundary_last", int'(bus.last_cnt), 1);
    tog(); step(2); tog(); step(14);
    check("next_window_done", int'(bus.window_done), 1);
    check("next_window_last", int'(bus.last_cnt), 2);

    // en dropped mid-window with two edges counted
    tog(); step(2); tog(); step(5);
    bus.en = 1'b0; step(1);
    check("en_drop_state", int'(bus.state), 0);
    check("en_drop_done", int'(bus.window_done), 0);
    check("en_drop_last", int'(bus.last_cnt), 2);
    step(5);
    bus.en = 1'b1; step(20);

    // Clear with en low lands in IDLE
    bus.en = 1'b0; bus.clear = 1'b1; step(1); bus.clear = 1'b0;
    check("clear_idle_state", int'(bus.state), 0);

    // Alarm, then asynchronous reset mid-cycle with sig_in held high
    bus.en = 1'b1; step(2);
    for (int i = 0; i < 5; i++) begin
      tog(); step(1);
    end
    step(3);
    check("alarm2_set", int'(bus.alarm), 1);
    #1 rst_n = 1'b0; bus.sig_in = 1'b1;
    #1;
    check("async_rst_alarm", int'(bus.alarm), 0);
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_done", int'(bus.window_done), 0);
    check("async_rst_last", int'(bus.last_cnt), 0);
    #1 rst_n = 1'b1;
    step(17);
    check("high_at_release_done", int'(bus.window_done), 1);
    check("high_at_release_last", int'(bus.last_cnt), 1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
